// File: rtl/audio_pkg.sv
// Shared constants and types for the audio mixer / PDM output path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package audio_pkg;

  localparam int IN_BITS     = 13;  // voice channel sample width (unsigned)
  localparam int SAMPLE_BITS = 16;  // published sample / PDM input width
  localparam int VOL_SHIFT   = 4;   // gain = (vol+1) / 2**VOL_SHIFT

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } mix_state_t;

endpackage

// File: rtl/pdm_dac_1st.sv
// First-order sigma-delta modulator: unsigned WIDTH-bit level in, 1-bit PDM out.
// Latency: din affects pdm_out on the edge after it is presented; runs every clk.
// Backpressure: none, free-running; density of ones = din / 2**WIDTH.
// Ports: clk, rst_n (sync, active-low), din (level), pdm_out (bitstream).
module pdm_dac_1st #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic             pdm_out
);

  logic [WIDTH-1:0] err;
  logic [WIDTH:0]   sum;

  // Carry out of the error accumulator is the output bit; the residue wraps.
  assign sum = {1'b0, err} + {1'b0, din};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= '0;
      pdm_out <= 1'b0;
    end else begin
      err     <= sum[WIDTH-1:0];
      pdm_out <= sum[WIDTH];
    end
  end

endmodule

// File: rtl/audio_mix_pdm.sv
// Voice mixer: snapshot NUM_CH channels on sample_clk, serial sum, volume scale, PDM out.
// Latency: sample_valid rises NUM_CH+1 edges after the capture edge; busy NUM_CH+1 cycles.
// Backpressure: none; a sample_clk while busy is dropped and sets sticky overrun.
// Ports: clk, rst_n (sync, active-low), sample_clk, ch_audio, ch_enable, master_vol in;
//        sample_out, sample_valid, overrun, pdm_out out.
module audio_mix_pdm
  import audio_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IN_BITS  = audio_pkg::IN_BITS,
  parameter int ACC_BITS = IN_BITS + $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_clk,
  input  logic [NUM_CH*IN_BITS-1:0] ch_audio,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [3:0]                master_vol,
  output logic [SAMPLE_BITS-1:0]    sample_out,
  output logic                      sample_valid,
  output logic                      overrun,
  output logic                      pdm_out
);

  localparam int IDX_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAD_BITS = SAMPLE_BITS - ACC_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CH - 1);

  mix_state_t state, state_nxt;
  logic capture, accum_en, scale_en, overrun_set;

  logic [IN_BITS-1:0]   snap_ch [NUM_CH];
  logic [NUM_CH-1:0]    snap_en;
  logic [3:0]           snap_vol;
  logic [IDX_BITS-1:0]  idx;
  logic [ACC_BITS-1:0]  acc;

  logic [ACC_BITS-1:0]           ch_term;
  logic [VOL_SHIFT:0]            vol_gain;
  logic [ACC_BITS+VOL_SHIFT:0]   prod;
  logic [ACC_BITS-1:0]           scaled;
  logic [SAMPLE_BITS-1:0]        sample_nxt;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accum_en  = 1'b0;
    scale_en  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_clk) begin
          capture   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        accum_en = 1'b1;
        if (idx == LAST_IDX) state_nxt = SCALE;
      end
      SCALE: begin
        scale_en  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A strobe during ACCUM or SCALE (including the SCALE cycle) is lost.
  assign overrun_set = sample_clk && (state != IDLE);

  // ---------------- datapath ----------------
  assign ch_term  = snap_en[idx] ? ACC_BITS'(snap_ch[idx]) : '0;
  assign vol_gain = {1'b0, snap_vol} + {{VOL_SHIFT{1'b0}}, 1'b1};
  assign prod     = {{(VOL_SHIFT+1){1'b0}}, acc} * {{ACC_BITS{1'b0}}, vol_gain};
  // gain <= 1, so the shifted product always fits back in ACC_BITS.
  assign scaled     = ACC_BITS'(prod >> VOL_SHIFT);
  assign sample_nxt = SAMPLE_BITS'(scaled) << PAD_BITS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) snap_ch[k] <= '0;
      snap_en      <= '0;
      snap_vol     <= '0;
      idx          <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (overrun_set) overrun <= 1'b1;
      if (capture) begin
        for (int k = 0; k < NUM_CH; k++) snap_ch[k] <= ch_audio[k*IN_BITS +: IN_BITS];
        snap_en  <= ch_enable;
        snap_vol <= master_vol;
        idx      <= '0;
        acc      <= '0;
      end
      if (accum_en) begin
        acc <= acc + ch_term;
        idx <= idx + IDX_BITS'(1);
      end
      if (scale_en) begin
        sample_out   <= sample_nxt;
        sample_valid <= 1'b1;
      end
    end
  end

  // Driven from the registered sample so a new value takes effect the edge after sample_valid.
  pdm_dac_1st #(
    .WIDTH (SAMPLE_BITS)
  ) u_pdm (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (sample_out),
    .pdm_out (pdm_out)
  );

endmodule

// File: tb/tb_audio_mix_pdm.sv
// Self-checking bench for audio_mix_pdm: scoreboard of expected samples plus per-feature tasks.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_mix_pdm;

  localparam int NUM_CH  = 4;
  localparam int IN_BITS = 13;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      sample_clk = 1'b0;
  logic [NUM_CH*IN_BITS-1:0] ch_audio = '0;
  logic [NUM_CH-1:0]         ch_enable = '0;
  logic [3:0]                master_vol = '0;
  logic [15:0]               sample_out;
  logic                      sample_valid;
  logic                      overrun;
  logic                      pdm_out;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_val;

  audio_mix_pdm #(
    .NUM_CH (NUM_CH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_clk   (sample_clk),
    .ch_audio     (ch_audio),
    .ch_enable    (ch_enable),
    .master_vol   (master_vol),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .pdm_out      (pdm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: sum enabled channels, scale by (vol+1)/16, left-align 15 -> 16 bits.
  function automatic int model(input logic [NUM_CH*IN_BITS-1:0] ch,
                               input logic [NUM_CH-1:0] en, input logic [3:0] vol);
    int sum;
    sum = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (en[k]) sum += int'(ch[k*IN_BITS +: IN_BITS]);
    return ((sum * (int'(vol) + 1)) / 16) * 2;
  endfunction

  function automatic logic [NUM_CH*IN_BITS-1:0] pack4(input int a, input int b,
                                                       input int c, input int d);
    return {13'(d), 13'(c), 13'(b), 13'(a)};
  endfunction

  // Scoreboard consumer: every sample_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (sample_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: sample_out=%0d, required no sample_valid", sample_out);
      end else begin
        exp_val = exp_q.pop_front();
        if (sample_out !== 16'(exp_val)) begin
          errors++;
          $display("FAIL sample_out: got %0d, required %0d", sample_out, exp_val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; the strobe is captured on the next edge.
  task automatic drive_strobe(input logic [NUM_CH*IN_BITS-1:0] ch, input logic [NUM_CH-1:0] en,
                              input logic [3:0] vol, input bit push);
    ch_audio   = ch;
    ch_enable  = en;
    master_vol = vol;
    sample_clk = 1'b1;
    if (push) exp_q.push_back(model(ch, en, vol));
    @(posedge clk);
    #1;
    sample_clk = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d samples outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (sample_out !== 16'd0) begin errors++; $display("FAIL reset_sample_out: got %0d, required 0", sample_out); end
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", sample_valid); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    checks++;
    if (pdm_out !== 1'b0) begin errors++; $display("FAIL reset_pdm: got %b, required 0", pdm_out); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_scale();
    int lat;
    lat = 0;
    drive_strobe(pack4(4095, 4095, 4095, 4095), 4'hF, 4'd15, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (sample_valid === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != NUM_CH + 1) begin
      errors++;
      $display("FAIL latency: valid %0d edges after capture, required %0d", lat, NUM_CH + 1);
    end
    step();
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b one cycle later, required 0", sample_valid); end
    checks++;
    if (sample_out !== 16'd32760) begin errors++; $display("FAIL sample_hold: got %0d, required 32760", sample_out); end
    wait_drain();
  endtask

  task automatic test_vol_zero();
    drive_strobe(pack4(4095, 4095, 4095, 4095), 4'hF, 4'd0, 1'b1);
    wait_drain();
  endtask

  task automatic test_mask();
    drive_strobe(pack4(100, 8191, 300, 8191), 4'b0101, 4'd15, 1'b1);
    wait_drain();
  endtask

  task automatic test_snapshot();
    drive_strobe(pack4(4095, 4095, 4095, 4095), 4'hF, 4'd15, 1'b1);
    ch_audio   = '0;
    master_vol = 4'd0;
    wait_drain();
  endtask

  task automatic test_pdm_density();
    int ones;
    ones = 0;
    drive_strobe(pack4(4095, 4095, 4095, 4095), 4'hF, 4'd15, 1'b1);
    wait_drain();
    step();
    for (int i = 0; i < 65536; i++) begin
      step();
      if (pdm_out === 1'b1) ones++;
    end
    checks++;
    if (ones < 32759 || ones > 32761) begin
      errors++;
      $display("FAIL pdm_density: %0d ones in 65536, required 32760 +/-1", ones);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b, required 0", overrun); end
    drive_strobe(pack4(1000, 2000, 3000, 4000), 4'hF, 4'd7, 1'b1);
    step();
    step();
    drive_strobe(pack4(8191, 8191, 8191, 8191), 4'hF, 4'd15, 1'b0);
    wait_drain();
    repeat (NUM_CH + 3) step();
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    repeat (20) step();
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
    rst_n = 1'b0;
    step();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b, required 0", overrun); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_accum();
    int seen;
    seen = 0;
    drive_strobe(pack4(100, 8191, 300, 8191), 4'b0101, 4'd15, 1'b1);
    wait_drain();
    drive_strobe(pack4(4095, 4095, 4095, 4095), 4'hF, 4'd15, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if (sample_out !== 16'd0) begin errors++; $display("FAIL midrst_sample_out: got %0d, required 0", sample_out); end
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", sample_valid); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b, required 0", overrun); end
    checks++;
    if (pdm_out !== 1'b0) begin errors++; $display("FAIL midrst_pdm: got %b, required 0", pdm_out); end
    rst_n = 1'b1;
    for (int i = 0; i < NUM_CH + 4; i++) begin
      step();
      if (sample_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_valid: %0d valids, required 0", seen); end
    checks++;
    if (sample_out !== 16'd0) begin errors++; $display("FAIL midrst_hold: got %0d, required 0", sample_out); end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_vol_zero();
    test_mask();
    test_snapshot();
    test_pdm_density();
    test_overrun();
    test_reset_mid_accum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
